// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Contents : Shared types and encodings for the pipeline hazard controller.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERR     = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int DM_TIMEOUT_DEF = 16;

    // $0 is hard-wired, so it can never be the subject of a dependency.
    function automatic logic src_match(input logic       use_rs,
                                       input logic [4:0] rs,
                                       input logic       use_rt,
                                       input logic [4:0] rt,
                                       input logic [4:0] r);
        return (r != 5'd0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_unit
//  Contents : ALU operand forwarding select; EX/MEM result beats MEM/WB data.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_rf_wr,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_rf_wr,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] mem_rd,
                                           input logic       mem_wr,
                                           input logic [4:0] wb_rd,
                                           input logic       wb_wr);
        if (mem_wr && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return FWD_EXMEM;
        end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    assign o_fwd_a = fwd_sel(i_ex_rs, i_mem_rd, i_mem_rf_wr, i_wb_rd, i_wb_rf_wr);
    assign o_fwd_b = fwd_sel(i_ex_rt, i_mem_rd, i_mem_rf_wr, i_wb_rd, i_wb_rf_wr);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Contents : 5-stage pipeline sequencer: stage enables/flushes, RAW hazard
//             stalls, branch squash and data-memory handshake with timeout.
//             Define PIPE_FWD_EN to enable operand forwarding (load-use only
//             stalls); otherwise every RAW dependency on EX/MEM stalls.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DM_TIMEOUT = DM_TIMEOUT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IdRs,
    input  logic [4:0]       IdRt,
    input  logic             IdUseRs,
    input  logic             IdUseRt,
    input  logic [4:0]       ExRs,
    input  logic [4:0]       ExRt,
    input  logic [4:0]       ExRd,
    input  logic             ExRFWr,
    input  logic             ExMemR,
    input  logic [4:0]       MemRd,
    input  logic             MemRFWr,
    input  logic             MemMemR,
    input  logic             MemMemW,
    input  logic [4:0]       WbRd,
    input  logic             WbRFWr,
    input  logic             BrTaken,
    input  logic             DmAck,
    output logic             DmReq,
    output logic             PcWr,
    output logic             IfIdWr,
    output logic             IdExWr,
    output logic             ExMemWr,
    output logic             MemWbWr,
    output logic             IfIdFlush,
    output logic             IdExFlush,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             Halt,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int c_WCNT_W = $clog2(DM_TIMEOUT) + 1;

    // {PcWr, IfIdWr, IdExWr, ExMemWr, MemWbWr, IfIdFlush, IdExFlush}
    localparam logic [6:0] c_CTL_RUN    = 7'b11111_00;
    localparam logic [6:0] c_CTL_BRANCH = 7'b11111_11;
    localparam logic [6:0] c_CTL_HAZARD = 7'b00111_01;

    state_t                r_state_q, w_state_d;
    logic [c_WCNT_W-1:0]   r_wcnt_q,  w_wcnt_d;
    logic [CNT_W-1:0]      r_stall_q, w_stall_d;

    logic                  w_mem_acc;
    logic                  w_ack;
    logic                  w_hazard;
    logic                  w_dmreq;
    logic [6:0]            w_run_ctl;
    logic [6:0]            w_ctl;
    logic [1:0]            w_fwd_a;
    logic [1:0]            w_fwd_b;

    assign w_mem_acc = MemMemR | MemMemW;
    assign w_ack     = DmAck & w_mem_acc;

`ifdef PIPE_FWD_EN
    fwd_unit u_fwd (
        .i_ex_rs     (ExRs),
        .i_ex_rt     (ExRt),
        .i_mem_rd    (MemRd),
        .i_mem_rf_wr (MemRFWr),
        .i_wb_rd     (WbRd),
        .i_wb_rf_wr  (WbRFWr),
        .o_fwd_a     (w_fwd_a),
        .o_fwd_b     (w_fwd_b)
    );

    assign w_hazard = ExMemR & ExRFWr & src_match(IdUseRs, IdRs, IdUseRt, IdRt, ExRd);
`else
    logic w_unused_nofwd;

    assign w_fwd_a = FWD_RF;
    assign w_fwd_b = FWD_RF;
    // WB writes through the register file, so only EX and MEM producers stall.
    assign w_hazard = (ExRFWr  & src_match(IdUseRs, IdRs, IdUseRt, IdRt, ExRd)) |
                      (MemRFWr & src_match(IdUseRs, IdRs, IdUseRt, IdRt, MemRd));
    assign w_unused_nofwd = ^{ExRs, ExRt, WbRd, WbRFWr, ExMemR};
`endif

    always_comb begin
        w_run_ctl = c_CTL_RUN;
        if (BrTaken) begin
            w_run_ctl = c_CTL_BRANCH;
        end else if (w_hazard) begin
            w_run_ctl = c_CTL_HAZARD;
        end

        w_ctl     = '0;
        w_dmreq   = 1'b0;
        w_state_d = r_state_q;
        w_wcnt_d  = r_wcnt_q;

        case (r_state_q)
            ST_RUN: begin
                w_dmreq = w_mem_acc;
                if (w_mem_acc && !DmAck) begin
                    w_state_d = ST_MEMWAIT;
                    w_wcnt_d  = c_WCNT_W'(1);
                end else begin
                    w_ctl = w_run_ctl;
                end
            end
            ST_MEMWAIT: begin
                w_dmreq = w_mem_acc;
                if (w_ack) begin
                    w_ctl     = w_run_ctl;
                    w_state_d = ST_RUN;
                    w_wcnt_d  = '0;
                end else if (r_wcnt_q == c_WCNT_W'(DM_TIMEOUT - 1)) begin
                    w_state_d = ST_ERR;
                end else begin
                    w_wcnt_d = r_wcnt_q + c_WCNT_W'(1);
                end
            end
            default: begin
                w_state_d = ST_ERR;
            end
        endcase

        w_stall_d = r_stall_q;
        if (!w_ctl[6] && (r_stall_q != {CNT_W{1'b1}})) begin
            w_stall_d = r_stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_RUN;
            r_wcnt_q  <= '0;
            r_stall_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_wcnt_q  <= w_wcnt_d;
            r_stall_q <= w_stall_d;
        end
    end

    // Outputs are forced quiet for the whole reset window, not just at the edge.
    assign {PcWr, IfIdWr, IdExWr, ExMemWr, MemWbWr, IfIdFlush, IdExFlush} = rst ? 7'b0 : w_ctl;
    assign DmReq    = ~rst & w_dmreq;
    assign FwdA     = rst ? FWD_RF : w_fwd_a;
    assign FwdB     = rst ? FWD_RF : w_fwd_b;
    assign Halt     = ~rst & (r_state_q == ST_ERR);
    assign StallCnt = r_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Contents : Scoreboard bench for pipe_hazard_ctrl (either forwarding build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int DMT = 4;
    localparam int CW  = 4;
`ifdef PIPE_FWD_EN
    localparam bit FWD_BUILD = 1'b1;
`else
    localparam bit FWD_BUILD = 1'b0;
`endif

    localparam logic [6:0] CTL_RUN = 7'b11111_00;
    localparam logic [6:0] CTL_BR  = 7'b11111_11;
    localparam logic [6:0] CTL_HAZ = 7'b00111_01;
    localparam logic [6:0] CTL_FRZ = 7'b00000_00;
    localparam logic [6:0] CTL_NOFWD_HAZ = FWD_BUILD ? CTL_RUN : CTL_HAZ;

    typedef struct {
        logic [12:0] v;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    IdRs, IdRt, ExRs, ExRt, ExRd, MemRd, WbRd;
    logic          IdUseRs, IdUseRt, ExRFWr, ExMemR, MemRFWr, MemMemR, MemMemW;
    logic          WbRFWr, BrTaken, DmAck;
    logic          DmReq, PcWr, IfIdWr, IdExWr, ExMemWr, MemWbWr, IfIdFlush, IdExFlush, Halt;
    logic [1:0]    FwdA, FwdB;
    logic [CW-1:0] StallCnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DM_TIMEOUT(DMT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IdRs(IdRs), .IdRt(IdRt), .IdUseRs(IdUseRs), .IdUseRt(IdUseRt),
        .ExRs(ExRs), .ExRt(ExRt), .ExRd(ExRd), .ExRFWr(ExRFWr), .ExMemR(ExMemR),
        .MemRd(MemRd), .MemRFWr(MemRFWr), .MemMemR(MemMemR), .MemMemW(MemMemW),
        .WbRd(WbRd), .WbRFWr(WbRFWr), .BrTaken(BrTaken), .DmAck(DmAck),
        .DmReq(DmReq), .PcWr(PcWr), .IfIdWr(IfIdWr), .IdExWr(IdExWr),
        .ExMemWr(ExMemWr), .MemWbWr(MemWbWr), .IfIdFlush(IfIdFlush), .IdExFlush(IdExFlush),
        .FwdA(FwdA), .FwdB(FwdB), .Halt(Halt), .StallCnt(StallCnt)
    );

    // Scoreboard consumer: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t        e;
            logic [12:0] act;
            e   = sb_q.pop_front();
            act = {PcWr, IfIdWr, IdExWr, ExMemWr, MemWbWr, IfIdFlush, IdExFlush,
                   DmReq, Halt, FwdA, FwdB};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: actual ctl/req/halt/fwd=%b required=%b", e.name, act, e.v);
            end
        end
    end

    task automatic clear_inputs();
        IdRs = 0; IdRt = 0; IdUseRs = 0; IdUseRt = 0;
        ExRs = 0; ExRt = 0; ExRd = 0; ExRFWr = 0; ExMemR = 0;
        MemRd = 0; MemRFWr = 0; MemMemR = 0; MemMemW = 0;
        WbRd = 0; WbRFWr = 0; BrTaken = 0; DmAck = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string n, input logic [6:0] ctl, input logic req,
                              input logic halt, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.v    = {ctl, req, halt, fa, fb};
        e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        BrTaken = 1; MemMemW = 1; ExRd = 8; ExRFWr = 1; ExMemR = 1; IdRs = 8; IdUseRs = 1;
        MemRd = 9; MemRFWr = 1; ExRs = 9; ExRt = 9;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({PcWr, IfIdWr, IdExWr, ExMemWr, MemWbWr, IfIdFlush, IdExFlush} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: actual=%b required=0000000",
                     {PcWr, IfIdWr, IdExWr, ExMemWr, MemWbWr, IfIdFlush, IdExFlush});
        end
        checks++;
        if (DmReq !== 1'b0) begin errors++; $display("FAIL reset_dmreq: actual=%b required=0", DmReq); end
        checks++;
        if ({FwdA, FwdB} !== 4'b0) begin errors++; $display("FAIL reset_fwd: actual=%b required=0000", {FwdA, FwdB}); end
        checks++;
        if (Halt !== 1'b0) begin errors++; $display("FAIL reset_halt: actual=%b required=0", Halt); end
        checks++;
        if (StallCnt !== '0) begin errors++; $display("FAIL reset_stallcnt: actual=%0d required=0", StallCnt); end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        next_cycle();
        ExRd = 8; ExRFWr = 1; ExMemR = 1; IdRs = 8; IdUseRs = 1;
        expect_cyc("loaduse_bubble", CTL_HAZ, 0, 0, 2'b00, 2'b00);
        next_cycle();
        checks++;
        if (StallCnt !== 4'd1) begin errors++; $display("FAIL loaduse_stallcnt: actual=%0d required=1", StallCnt); end
        clear_inputs();
        expect_cyc("loaduse_resume", CTL_RUN, 0, 0, 2'b00, 2'b00);
        next_cycle();
        checks++;
        if (StallCnt !== 4'd1) begin errors++; $display("FAIL loaduse_stallcnt_hold: actual=%0d required=1", StallCnt); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        next_cycle();
        ExRd = 0; ExRFWr = 1; ExMemR = 1; IdRs = 0; IdUseRs = 1; IdRt = 0; IdUseRt = 1;
        MemRd = 0; MemRFWr = 1;
        expect_cyc("zero_dest", CTL_RUN, 0, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
        ExRd = 8; ExRFWr = 1; ExMemR = 1; IdRs = 8; IdUseRs = 0;
        expect_cyc("unused_src", CTL_RUN, 0, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
        checks++;
        if (StallCnt !== 4'd0) begin errors++; $display("FAIL zero_stallcnt: actual=%0d required=0", StallCnt); end
    endtask

    task automatic test_no_fwd_stall();
        do_reset();
        next_cycle();
        MemRFWr = 1; MemRd = 5; IdRt = 5; IdUseRt = 1;
        expect_cyc("mem_raw", CTL_NOFWD_HAZ, 0, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
        ExRFWr = 1; ExRd = 7; IdRs = 7; IdUseRs = 1;
        expect_cyc("ex_alu_raw", CTL_NOFWD_HAZ, 0, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
        checks++;
        if (StallCnt !== (FWD_BUILD ? 4'd0 : 4'd2)) begin
            errors++;
            $display("FAIL raw_stallcnt: actual=%0d required=%0d", StallCnt, FWD_BUILD ? 0 : 2);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        next_cycle();
        MemRd = 9; WbRd = 9; MemRFWr = 1; WbRFWr = 1; ExRs = 9; ExRt = 3;
        expect_cyc("fwd_exmem", CTL_RUN, 0, 0, FWD_BUILD ? 2'b01 : 2'b00, 2'b00);
        next_cycle();
        MemRFWr = 0;
        expect_cyc("fwd_memwb", CTL_RUN, 0, 0, FWD_BUILD ? 2'b10 : 2'b00, 2'b00);
        next_cycle();
        MemRFWr = 1; ExRt = 9;
        expect_cyc("fwd_both", CTL_RUN, 0, 0, FWD_BUILD ? 2'b01 : 2'b00, FWD_BUILD ? 2'b01 : 2'b00);
        next_cycle();
        MemRd = 0; WbRd = 0; ExRs = 0; ExRt = 0;
        expect_cyc("fwd_zero", CTL_RUN, 0, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        do_reset();
        next_cycle();
        BrTaken = 1; ExRd = 8; ExRFWr = 1; ExMemR = 1; IdRs = 8; IdUseRs = 1;
        expect_cyc("branch_vs_loaduse", CTL_BR, 0, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
        BrTaken = 1;
        expect_cyc("branch_only", CTL_BR, 0, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
        checks++;
        if (StallCnt !== 4'd0) begin errors++; $display("FAIL branch_stallcnt: actual=%0d required=0", StallCnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            MemMemW = 1;
            expect_cyc($sformatf("memwait_frozen%0d", i), CTL_FRZ, 1, 0, 2'b00, 2'b00);
        end
        next_cycle();
        DmAck = 1;
        expect_cyc("memwait_release", CTL_RUN, 1, 0, 2'b00, 2'b00);
        next_cycle();
        checks++;
        if (StallCnt !== 4'd3) begin errors++; $display("FAIL memwait_stallcnt: actual=%0d required=3", StallCnt); end
        clear_inputs();
        expect_cyc("memwait_req_drop", CTL_RUN, 0, 0, 2'b00, 2'b00);
        next_cycle();
        MemMemR = 1; DmAck = 1;
        expect_cyc("zero_wait", CTL_RUN, 1, 0, 2'b00, 2'b00);
        next_cycle();
        MemMemR = 0; DmAck = 1;
        expect_cyc("stray_ack", CTL_RUN, 0, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
        MemMemW = 1; ExRd = 8; ExRFWr = 1; ExMemR = 1; IdRs = 8; IdUseRs = 1;
        expect_cyc("frozen_holds_hazard", CTL_FRZ, 1, 0, 2'b00, 2'b00);
        next_cycle();
        DmAck = 1;
        expect_cyc("release_into_hazard", CTL_HAZ, 1, 0, 2'b00, 2'b00);
        next_cycle();
        clear_inputs();
        checks++;
        if (StallCnt !== 4'd5) begin errors++; $display("FAIL memwait_stallcnt2: actual=%0d required=5", StallCnt); end
        expect_cyc("memwait_done", CTL_RUN, 0, 0, 2'b00, 2'b00);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < DMT; i++) begin
            next_cycle();
            MemMemR = 1;
            expect_cyc($sformatf("timeout_wait%0d", i), CTL_FRZ, 1, 0, 2'b00, 2'b00);
        end
        next_cycle();
        checks++;
        if (StallCnt !== 4'd4) begin errors++; $display("FAIL timeout_stallcnt: actual=%0d required=4", StallCnt); end
        for (int i = 0; i < 12; i++) begin
            DmAck = (i == 1);
            expect_cyc($sformatf("err_hold%0d", i), CTL_FRZ, 0, 1, 2'b00, 2'b00);
            next_cycle();
        end
        checks++;
        if (StallCnt !== 4'd15) begin errors++; $display("FAIL stallcnt_saturate: actual=%0d required=15", StallCnt); end
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (Halt !== 1'b0) begin errors++; $display("FAIL err_reset_halt: actual=%b required=0", Halt); end
        checks++;
        if (StallCnt !== '0) begin errors++; $display("FAIL err_reset_stallcnt: actual=%0d required=0", StallCnt); end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        expect_cyc("after_err_reset", CTL_RUN, 0, 0, 2'b00, 2'b00);
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_no_fwd_stall();
        test_forwarding();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage MIPS core. It drives the write-enable and flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and detects RAW hazards, both load-use and, without forwarding, all of them. It selects ALU operand forwarding, resolves taken-branch squashes, and runs the data-memory request/acknowledge handshake with a timeout.

## Interface
- DM_TIMEOUT, 16: max MEMWAIT cycles before error (≥2)
- CNT_W, 32: stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- IdRs, IdRt  in  5  ID-stage source registers
- IdUseRs, IdUseRt  in  1  ID instruction actually reads Rs/Rt
- ExRs, ExRt  in  5  EX-stage source registers
- ExRd  in  5  EX destination; ExRFWr, ExMemR  in  1  EX writes RF / is load
- MemRd  in  5  MEM destination; MemRFWr, MemMemR, MemMemW  in  1
- WbRd  in  5  WB destination; WbRFWr  in  1
- BrTaken  in  1  branch/jump resolved taken in EX
- DmAck  in  1  data memory completes access this cycle
- DmReq  out  1  data memory request
- PcWr, IfIdWr, IdExWr, ExMemWr, MemWbWr  out  1  stage enables
- IfIdFlush, IdExFlush  out  1  load bubble (all-zero control) instead of data
- FwdA, FwdB  out  2  00 RF, 01 EX/MEM ALU result, 10 MEM/WB write data
- Halt  out  1  sticky memory-timeout error
- StallCnt  out  CNT_W  cycles with PcWr=0, saturating

## Operation
- FSM states RUN, MEMWAIT, ERR; reset → RUN, wait counter 0, StallCnt 0, Halt 0.
- MemAcc = MemMemR | MemMemW. DmReq = MemAcc in RUN or MEMWAIT; 0 in ERR.
- RUN, MemAcc & !DmAck: freeze all (every Wr=0, no flush), → MEMWAIT, counter=1.
- RUN, MemAcc & DmAck (zero-wait): treat as no memory stall.
- MEMWAIT: freeze all; DmAck → apply normal RUN decision this cycle, → RUN, counter=0; else counter==DM_TIMEOUT-1 → ERR; else counter+1.
- ERR: all Wr=0, flushes 0, DmReq=0, Halt=1; exits only via rst.
- Normal decision (unfrozen), priority high→low:
  - BrTaken: PcWr=1, IfIdFlush=1, IdExFlush=1, others Wr=1.
  - Data hazard: PcWr=0, IfIdWr=0, IdExFlush=1, ExMemWr=MemWbWr=1.
  - Else all Wr=1, no flush.
- Source match: (IdUseRs & IdRs==R) | (IdUseRt & IdRt==R), with R≠0.
- Frozen cycles hold BrTaken/hazard; they are re-evaluated on release.
- StallCnt increments each cycle PcWr=0 (incl. ERR), saturating at all-ones.

## Timing
- Stage controls, DmReq and Fwd are combinational from state plus inputs, with no extra latency.
- While rst is high, all Wr=0, flushes 0, DmReq=0, Fwd=00, Halt=0, StallCnt=0.
- Reset mid-MEMWAIT aborts the access: DmReq drops the same cycle.
- Load-use costs exactly 1 bubble. Memory access costs N stall cycles when DmAck arrives N cycles after DmReq rises.
- DmAck outside MemAcc is ignored.

## Configuration
- PIPE_FWD_EN defined:
  - FwdA selects 01 if MemRFWr & MemRd≠0 & MemRd==ExRs.
  - Else it selects 10 if WbRFWr & WbRd≠0 & WbRd==ExRs.
  - Else it selects 00. FwdB is identical with ExRt.
  - The data hazard is load-use only: ExMemR & ExRFWr & source match on ExRd.
- Undefined:
  - FwdA=FwdB=00 constant.
  - The data hazard is any source match on ExRd (ExRFWr) or MemRd (MemRFWr).
  - WB is write-through in the RF, so it needs no stall.

## Structure
- Package pipe_ctrl_pkg: state enum, FWD_RF/FWD_EXMEM/FWD_MEMWB encodings, DM_TIMEOUT default.
- Sub-module fwd_unit holds the forwarding comparators, instantiated only under PIPE_FWD_EN. The FSM, hazard priority and counters stay in the top.

## Test plan
- Load-use: lw $8 in EX, ID add uses $8 (IdUseRs=1).
  - Response: 1 cycle of PcWr=0, IfIdWr=0, IdExFlush=1, then all Wr=1. StallCnt=1.
- Forwarding (FWD_EN): MemRd=WbRd=9, both RFWr, ExRs=9 → FwdA=01. Drop MemRFWr → FwdA=10.
- Branch + load-use same cycle: BrTaken=1 wins.
  - Response: PcWr=1, IfIdFlush=IdExFlush=1.
- Memory wait: sw in MEM, DmAck 3 cycles after DmReq rises.
  - Response: 3 frozen cycles, release on the ack cycle, DmReq low next cycle.
- Timeout: DM_TIMEOUT=4, no DmAck.
  - Response: ERR entered, Halt=1, DmReq=0, held until rst. rst → RUN, StallCnt=0.
- No-FWD build: MemRFWr, MemRd=5, IdRt=5 used → stall; $0 destinations never stall.
